// File: rtl/csel_sub_pkg.sv
// ============================================================================
// Module   : csel_sub_pkg
// Brief    : Shared defaults and dual-result type for the carry-select subtractor
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package csel_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_BLOCK = 4;

  // Both borrow-in candidates of one block, sized for the default block width
  typedef struct packed {
    logic [DEFAULT_BLOCK-1:0] diff0;
    logic                     bout0;
    logic [DEFAULT_BLOCK-1:0] diff1;
    logic                     bout1;
  } csel_dual_t;

endpackage : csel_sub_pkg

`default_nettype wire

// File: rtl/csel_sub_block.sv
// ============================================================================
// Module   : csel_sub_block
// Brief    : BLOCK-bit subtract producing results for borrow-in 0 and 1
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csel_sub_block
  import csel_sub_pkg::*;
#(
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  output logic [BLOCK-1:0] o_diff0,
  output logic             o_bout0,
  output logic [BLOCK-1:0] o_diff1,
  output logic             o_bout1
);

  // One extra bit holds the sign: it is set exactly when the block borrows
  logic [BLOCK:0] w_d0;
  logic [BLOCK:0] w_d1;

  assign w_d0 = {1'b0, i_a} - {1'b0, i_b};
  assign w_d1 = w_d0 - {{BLOCK{1'b0}}, 1'b1};

  assign o_diff0 = w_d0[BLOCK-1:0];
  assign o_bout0 = w_d0[BLOCK];
  assign o_diff1 = w_d1[BLOCK-1:0];
  assign o_bout1 = w_d1[BLOCK];

endmodule : csel_sub_block

`default_nettype wire

// File: rtl/csel_subtractor_pipe.sv
// ============================================================================
// Module   : csel_subtractor_pipe
// Brief    : Two-stage valid/ready carry-select subtractor (a - b - bin).
//            Define CSEL_SUB_SAT_EN for unsigned saturating subtract.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csel_subtractor_pipe
  import csel_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int NBLK = WIDTH / BLOCK;

  if ((WIDTH % BLOCK) != 0 || WIDTH < BLOCK) begin : g_bad_cfg
    $error("csel_subtractor_pipe: WIDTH must be a non-zero multiple of BLOCK");
  end

  logic             r_s1_valid;
  logic [BLOCK-1:0] r_s1_lo;
  logic             r_s1_brw;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_s1_load;
  logic             w_s2_load;
  logic [BLOCK-1:0] w_lo_d0;
  logic [BLOCK-1:0] w_lo_d1;
  logic             w_lo_b0;
  logic             w_lo_b1;
  logic [WIDTH-1:0] w_s2_diff;
  logic             w_s2_brw;
  logic [WIDTH-1:0] w_res_diff;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign w_s1_load = in_valid && w_s1_adv;
  assign w_s2_load = r_s1_valid && w_s2_adv;
  assign in_ready  = w_s1_adv;

  csel_sub_block #(.BLOCK(BLOCK)) u_lo_blk (
    .i_a     (a[BLOCK-1:0]),
    .i_b     (b[BLOCK-1:0]),
    .o_diff0 (w_lo_d0),
    .o_bout0 (w_lo_b0),
    .o_diff1 (w_lo_d1),
    .o_bout1 (w_lo_b1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_lo    <= '0;
      r_s1_brw   <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
      end
      if (w_s1_load) begin
        r_s1_lo  <= bin ? w_lo_d1 : w_lo_d0;
        r_s1_brw <= bin ? w_lo_b1 : w_lo_b0;
      end
    end
  end

  if (NBLK > 1) begin : g_upper
    logic [WIDTH-BLOCK-1:0] r_a_hi;
    logic [WIDTH-BLOCK-1:0] r_b_hi;
    logic [WIDTH-BLOCK-1:0] w_hi;
    logic [NBLK-1:0]        w_brw;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_a_hi <= '0;
        r_b_hi <= '0;
      end else if (w_s1_load) begin
        r_a_hi <= a[WIDTH-1:BLOCK];
        r_b_hi <= b[WIDTH-1:BLOCK];
      end
    end

    assign w_brw[0] = r_s1_brw;

    // Every block precomputes both outcomes; the borrow only steers muxes
    for (genvar k = 0; k < NBLK - 1; k++) begin : g_blk
      logic [BLOCK-1:0] w_d0;
      logic [BLOCK-1:0] w_d1;
      logic             w_b0;
      logic             w_b1;

      csel_sub_block #(.BLOCK(BLOCK)) u_blk (
        .i_a     (r_a_hi[k*BLOCK +: BLOCK]),
        .i_b     (r_b_hi[k*BLOCK +: BLOCK]),
        .o_diff0 (w_d0),
        .o_bout0 (w_b0),
        .o_diff1 (w_d1),
        .o_bout1 (w_b1)
      );

      assign w_hi[k*BLOCK +: BLOCK] = w_brw[k] ? w_d1 : w_d0;
      assign w_brw[k+1]             = w_brw[k] ? w_b1 : w_b0;
    end

    assign w_s2_diff = {w_hi, r_s1_lo};
    assign w_s2_brw  = w_brw[NBLK-1];
  end else begin : g_single
    assign w_s2_diff = r_s1_lo;
    assign w_s2_brw  = r_s1_brw;
  end

`ifdef CSEL_SUB_SAT_EN
  assign w_res_diff = w_s2_brw ? '0 : w_s2_diff;
`else
  assign w_res_diff = w_s2_diff;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_diff     <= '0;
      r_bout     <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s2_load) begin
        r_diff <= w_res_diff;
        r_bout <= w_s2_brw;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;

endmodule : csel_subtractor_pipe

`default_nettype wire

// File: tb/tb_csel_subtractor_pipe.sv
// ============================================================================
// Module   : tb_csel_subtractor_pipe
// Brief    : Directed table, stall, mid-reset and random checks of the pipe
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csel_subtractor_pipe;

`ifdef CSEL_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;

  int errors;
  int checks;
  int n_rx;
  bit mon_en;
  logic [8:0] exp_q[$];

  csel_subtractor_pipe #(.WIDTH(8), .BLOCK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: {bout, diff} from a wide unsigned subtract
  function automatic logic [8:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
    logic [8:0] t;
    t = {1'b0, ma} - {1'b0, mb} - {8'd0, mbin};
    if (SAT && t[8]) t[7:0] = 8'h00;
    return t;
  endfunction

  logic       hold_chk;
  logic [7:0] hold_diff;
  logic       hold_bout;

  always @(posedge clk) begin
    if (mon_en && rst_n) begin
      if (hold_chk) begin
        chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
        chk("stall_diff_held", {24'd0, diff}, {24'd0, hold_diff});
        chk("stall_bout_held", {31'd0, bout}, {31'd0, hold_bout});
      end
      hold_chk  <= out_valid && !out_ready;
      hold_diff <= diff;
      hold_bout <= bout;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("stream_result", {23'd0, bout, diff}, {23'd0, e});
        end
        n_rx <= n_rx + 1;
      end
    end else begin
      hold_chk <= 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vbin;
    logic [7:0] vdiff;
    logic       vbout;
  } vec_t;

  vec_t tbl[12];
  logic [7:0] sa[5];
  logic [7:0] sb[5];
  logic       sbin[5];

  initial begin
    logic [7:0] ed;
    int         idx;
    int         sent;
    bit         saw_block;
    bit         acc;

    // Wrapping results; the saturating build zeroes diff where bout=1
    tbl[0]  = '{8'h66, 8'h66, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{8'hE7, 8'h77, 1'b0, 8'h70, 1'b0};
    tbl[2]  = '{8'h02, 8'h09, 1'b0, 8'hF9, 1'b1};
    tbl[3]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    tbl[4]  = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    tbl[5]  = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1};
    tbl[6]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[7]  = '{8'h80, 8'h01, 1'b1, 8'h7E, 1'b0};
    tbl[8]  = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
    tbl[9]  = '{8'h55, 8'hAA, 1'b0, 8'hAB, 1'b1};
    tbl[10] = '{8'h0F, 8'h10, 1'b0, 8'hFF, 1'b1};
    tbl[11] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0};

    sa[0] = 8'h12; sb[0] = 8'h34; sbin[0] = 1'b0;
    sa[1] = 8'hF0; sb[1] = 8'h0F; sbin[1] = 1'b1;
    sa[2] = 8'h80; sb[2] = 8'h80; sbin[2] = 1'b1;
    sa[3] = 8'h01; sb[3] = 8'h02; sbin[3] = 1'b0;
    sa[4] = 8'hC3; sb[4] = 8'h3C; sbin[4] = 1'b0;

    errors = 0; checks = 0; n_rx = 0; mon_en = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bin = 1'b0;

    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_diff", {24'd0, diff}, 32'd0);
    chk("reset_bout", {31'd0, bout}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vectors, one at a time, with exact latency checked
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a = tbl[i].va; b = tbl[i].vb; bin = tbl[i].vbin; in_valid = 1'b1;
      #1;
      chk("tbl_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("tbl_latency_early", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      ed = (SAT && tbl[i].vbout) ? 8'h00 : tbl[i].vdiff;
      chk("tbl_out_valid", {31'd0, out_valid}, 32'd1);
      chk("tbl_diff", {24'd0, diff}, {24'd0, ed});
      chk("tbl_bout", {31'd0, bout}, {31'd0, tbl[i].vbout});
    end
    repeat (2) @(negedge clk);

    // Back-to-back burst with out_ready low in cycles 3..6
    exp_q.delete();
    mon_en = 1'b1;
    idx = 0; saw_block = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 6);
      if (idx < 5) begin
        in_valid = 1'b1; a = sa[idx]; b = sb[idx]; bin = sbin[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(sa[idx], sb[idx], sbin[idx]));
        idx++;
      end
      if (idx == 5 && exp_q.size() == 0 && c > 8) break;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("burst_accepted", idx, 32'd5);
    chk("burst_in_ready_dropped", {31'd0, saw_block}, 32'd1);
    chk("burst_received", n_rx, 32'd5);
    chk("burst_drained", exp_q.size(), 32'd0);
    mon_en = 1'b0;
    repeat (2) @(negedge clk);

    // Fill both stages, then reset with results in flight
    out_ready = 1'b0;
    a = 8'h40; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 8'h41; b = 8'h02;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_reset_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_reset_diff", {24'd0, diff}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("post_reset_no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Random operands and random back-pressure against the model
    exp_q.delete();
    n_rx = 0;
    mon_en = 1'b1;
    sent = 0; acc = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (acc) begin
        in_valid = 1'b0; acc = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        bin = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, bin));
        sent++;
        acc = 1'b1;
      end
      if (sent == 1000 && exp_q.size() == 0) break;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("random_sent", sent, 32'd1000);
    chk("random_received", n_rx, 32'd1000);
    chk("random_drained", exp_q.size(), 32'd0);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_csel_subtractor_pipe

`default_nettype wire

// File: doc/csel_subtractor_pipe.md
CSEL_SUBTRACTOR_PIPE -- requirements
Module: csel_subtractor_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width; legal values are multiples of BLOCK.
REQ-002 SHALL provide parameter BLOCK, default 4, carry-select block width in bits.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand set on a, b, bin is valid.
REQ-007 in_ready  output  1  block can accept operands this cycle.
REQ-008 a  input  WIDTH  minuend.
REQ-009 b  input  WIDTH  subtrahend.
REQ-010 bin  input  1  borrow-in.
REQ-011 out_valid  output  1  diff and bout are valid.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 diff  output  WIDTH  a - b - bin, modulo 2^WIDTH, or saturated per REQ-027.
REQ-014 bout  output  1  borrow-out, 1 when a < b + bin as unsigned values.

Function
REQ-015 SHALL accept operands on a rising edge where in_valid and in_ready are both 1.
REQ-016 SHALL be a two-stage pipeline.
- Stage 1 registers the low BLOCK bits of the difference, the low-block borrow, and the remaining upper operand bits.
- Stage 2 computes each upper block for both borrow-in candidates (0 and 1), selects using the propagated borrow, and registers diff and bout.
REQ-017 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready is held at 1.
REQ-018 Throughput SHALL be one result per cycle when out_ready is held at 1.
REQ-019 Stage 2 SHALL advance when it is empty or when out_ready is 1; stage 1 advances when it is empty or when stage 2 advances.
REQ-020 in_ready SHALL equal (stage 1 empty) OR (stage 2 advances); in_ready is combinational from out_ready, with no other combinational input-to-output path.
REQ-021 While out_valid=1 and out_ready=0, diff and bout SHALL hold stable and no result SHALL be lost or duplicated.
REQ-022 Results SHALL emerge in acceptance order.
REQ-023 in_valid=1 with in_ready=0 SHALL not capture operands; the source must hold them.
REQ-024 bin=1 with a=b SHALL yield diff of all ones and bout=1.

Reset
REQ-025 On rst_n=0, both stage valid flags SHALL clear immediately, out_valid=0, diff=0, bout=0, and in_ready=1 after release.
REQ-026 Reset mid-operation SHALL discard in-flight results; no out_valid pulse SHALL appear for operands accepted before reset.

Configuration
REQ-027 Macro CSEL_SUB_SAT_EN SHALL control saturation.
- Defined: when bout=1, diff is forced to 0 (unsigned saturating subtract) and bout still reports 1.
- Undefined: diff wraps modulo 2^WIDTH.
- Timing and handshake SHALL be identical in both builds.

Structure
REQ-028 Package csel_sub_pkg SHALL hold DEFAULT_WIDTH, DEFAULT_BLOCK, and a typedef for the per-block dual result {diff0, bout0, diff1, bout1}.
REQ-029 Sub-module csel_sub_block SHALL implement one BLOCK-bit combinational block producing both borrow-in candidates.
- Stage 1 SHALL instantiate it once.
- Stage 2 SHALL instantiate it per upper block.

Verification
REQ-030 a=0x66, b=0x66, bin=0 -> diff=0x00, bout=0, out_valid exactly 2 cycles after acceptance.
REQ-031 a=0xE7, b=0x77, bin=0 -> diff=0x70, bout=0; a=0x02, b=0x09, bin=0 -> diff=0xF9, bout=1 (diff=0x00 with CSEL_SUB_SAT_EN).
REQ-032 a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1 (0x00 when saturating).
REQ-033 Five back-to-back operand sets with out_ready held 0 for cycles 3-6 -> in_ready drops once both stages are full; all five results appear in order with no loss or duplication.
REQ-034 rst_n asserted low while both stages hold data -> out_valid goes to 0 immediately, and no stale result appears after reset release.
REQ-035 Randomized 1000 operand pairs with random out_ready -> every result matches the a - b - bin reference model, including bout.
